// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: request/wait/hold FSM with redirect discard
package fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data_t;
endpackage

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   ireq_valid,
    output logic [31:0]            ireq_addr,
    input  logic                   iresp_addr_ok,
    input  logic                   iresp_data_ok,
    input  logic [31:0]            iresp_data,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output fetch_pkg::fetch_data_t fetch_data_reg,
    output logic                   fetch_valid
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [31:0]            r_pc;
    logic [31:0]            w_pc_nxt;
    // Address driven on the bus; frozen while a request is outstanding even if pc is redirected
    logic [31:0]            r_req_addr;
    logic [31:0]            w_req_addr_nxt;
    // Set when the in-flight response belongs to a stale pc and must be dropped
    logic                   r_discard;
    logic                   w_discard_nxt;
    logic                   w_latch;
    logic [31:0]            w_pc_inc;
    logic [31:0]            w_resume_pc;
    fetch_pkg::fetch_data_t r_fetch_data;

    assign w_pc_inc    = r_pc + 32'd4;
    assign w_resume_pc = redirect_valid ? redirect_pc : r_pc;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath next values and bus/decode outputs
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_addr_nxt = r_req_addr;
        w_discard_nxt  = r_discard;
        w_latch        = 1'b0;
        ireq_valid     = (r_state == S_REQ) && !reset;
        ireq_addr      = r_req_addr;
        fetch_valid    = (r_state == S_HOLD);
        fetch_data_reg = r_fetch_data;

        case (r_state)
            S_REQ: begin
                // Redirect retargets pc only; the bus address stays until accepted
                if (redirect_valid) begin
                    w_pc_nxt      = redirect_pc;
                    w_discard_nxt = 1'b1;
                end
                if (iresp_addr_ok) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (iresp_data_ok) begin
                    if (r_discard || redirect_valid) begin
                        w_state_nxt    = S_REQ;
                        w_discard_nxt  = 1'b0;
                        w_pc_nxt       = w_resume_pc;
                        w_req_addr_nxt = w_resume_pc;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    w_pc_nxt      = redirect_pc;
                    w_discard_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                // Redirect wins over stall and drops the held instruction
                if (redirect_valid) begin
                    w_pc_nxt       = redirect_pc;
                    w_req_addr_nxt = redirect_pc;
                    w_state_nxt    = S_REQ;
                end else if (!stall) begin
                    w_pc_nxt       = w_pc_inc;
                    w_req_addr_nxt = w_pc_inc;
                    w_state_nxt    = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // Datapath registers: pc, bus address, discard flag and the word handed to decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_discard    <= 1'b0;
            r_fetch_data <= '0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_discard  <= w_discard_nxt;
            if (w_latch) begin
                r_fetch_data <= {r_pc, iresp_data};
            end
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'hbfc0_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be asynchronous, active-high.
REQ-004 ireq_valid  out  1  SHALL flag an instruction-bus request.
REQ-005 ireq_addr  out  32  SHALL carry the request address.
REQ-006 iresp_addr_ok  in  1  SHALL signal that the memory accepted the address.
REQ-007 iresp_data_ok  in  1  SHALL signal that the instruction word is valid.
REQ-008 iresp_data  in  32  SHALL carry the instruction word.
REQ-009 stall  in  1  SHALL mean decode cannot accept this cycle (inverse of decode_enable).
REQ-010 redirect_valid  in  1  SHALL request a PC change (jump/branch).
REQ-011 redirect_pc  in  32  SHALL give the new PC.
REQ-012 fetch_data_reg  out  fetch_data_t  SHALL provide {pc, instruction} to decode.
REQ-013 fetch_valid  out  1  SHALL mark fetch_data_reg as holding a valid instruction.

Function
REQ-014 FSM states SHALL be REQ, WAIT and HOLD.
REQ-015 In REQ: ireq_valid=1, ireq_addr=pc, held stable until iresp_addr_ok; on iresp_addr_ok go to WAIT.
REQ-016 In WAIT: on iresp_data_ok with discard=0, latch {pc, iresp_data} into fetch_data_reg and go to HOLD.
REQ-017 iresp_data_ok SHALL be honoured only in WAIT; the bus never returns data_ok in the same cycle as addr_ok.
REQ-018 In HOLD: fetch_valid=1; when stall=0 the transfer completes, pc <= pc+4 (mod 2^32, wraps), go to REQ.
REQ-019 In HOLD with stall=1, fetch_data_reg and fetch_valid SHALL hold unchanged indefinitely.
REQ-020 fetch_valid SHALL be 1 only in HOLD; ireq_valid SHALL be 1 only in REQ.
REQ-021 Redirect in HOLD SHALL drop the held instruction (fetch_valid=0 next cycle), set pc <= redirect_pc and go to REQ; redirect SHALL override stall.
REQ-022 Redirect in REQ or WAIT SHALL set pc <= redirect_pc and set discard=1; the outstanding request address SHALL stay unchanged until addr_ok.
REQ-023 In WAIT with discard=1, iresp_data_ok SHALL drop the word, clear discard and go to REQ issuing the redirected pc.
REQ-024 Redirect in the same cycle as iresp_data_ok in WAIT SHALL discard that word (behaves as REQ-023).
REQ-025 Redirect in REQ in the same cycle as iresp_addr_ok SHALL go to WAIT with discard=1.
REQ-026 A later redirect while discard=1 SHALL overwrite pc only; a single discard covers the single outstanding request.
REQ-027 Latency: addr_ok at cycle N, data_ok at cycle M>N leads to fetch_valid=1 from cycle M+1.

Reset
REQ-028 While reset=1: state=REQ, pc=RESET_PC, discard=0, fetch_valid=0, fetch_data_reg=0, and ireq_valid forced to 0.
REQ-029 Reset asserted mid-transaction SHALL abandon it immediately; any data_ok arriving after reset release while in REQ SHALL be ignored.
REQ-030 The first cycle after reset release SHALL present ireq_valid=1, ireq_addr=RESET_PC.

Verification
REQ-031 Release reset, memory acks addr in cycle 1 and data 32'h2408_0001 in cycle 3 -> fetch_valid=1 in cycle 4 with pc=32'hbfc0_0000; stall=0 -> next ireq_addr=32'hbfc0_0004.
REQ-032 HOLD with stall=1 for 5 cycles -> fetch_data_reg constant, ireq_valid=0; stall drops -> one transfer, pc advances by 4.
REQ-033 Redirect to 32'hbfc0_0100 while in WAIT -> the returned word is dropped, fetch_valid stays 0, next ireq_addr=32'hbfc0_0100.
REQ-034 Redirect in HOLD with stall=1 -> fetch_valid=0 next cycle, ireq_addr=redirect_pc.
REQ-035 Memory withholds addr_ok for 4 cycles while redirect pulses -> ireq_addr stable at the old pc until addr_ok; the response is discarded; the next request goes to redirect_pc.
REQ-036 pc=32'hffff_fffc transferred -> next ireq_addr=32'h0000_0000; reset pulsed in WAIT -> ireq_valid=0 during reset, then REQ at RESET_PC.
